// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive FIFO slice.
// The optional dropped-character counter in uart_rx_fifo is enabled
// by the macro UART_RX_FIFO_OVR_CNT_EN.
package uart_pkg;

  // Default width of one received character.
  localparam int DATA_W_DEF = 8;

  // Default log2 of the FIFO depth.
  localparam int ADDR_W_DEF = 4;

  // Default FIFO depth in characters.
  localparam int FIFO_DEPTH = 2 ** ADDR_W_DEF;

  // Width of the dropped-character counter.
  localparam int OVR_CNT_W = 8;

  // Net pointer activity in one cycle.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/uart_fifo_regfile.sv
// Character storage for the UART receive FIFO.
// Writes are synchronous. The read port is asynchronous, which gives the
// FIFO its show-ahead behaviour. The array is deliberately left uncleared
// by reset; the owning FIFO tracks validity through its pointers.
module uart_fifo_regfile
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // Store the incoming character when the FIFO accepts a push.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: buffers characters from the receiver's done tick
// and presents the oldest one show-ahead on r_data.
// A push while full with no pop drops the character and sets a sticky
// overrun flag. When both push and pop are requested on a full FIFO, the
// pop frees a slot, so both are performed.
// Optional feature: define UART_RX_FIFO_OVR_CNT_EN to add ovr_count, a
// saturating 8-bit count of dropped characters.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              rd,
  output logic [DATA_W-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              overrun,
  input  logic              clr_overrun
`ifdef UART_RX_FIFO_OVR_CNT_EN
  ,
  output logic [OVR_CNT_W-1:0] ovr_count
`endif
);

  localparam logic [ADDR_W:0] LVL_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] LVL_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LVL_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic              r_empty;
  logic              r_full;
  logic              r_overrun;

  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  fifo_op_e          w_op;
  logic [ADDR_W:0]   w_level_next;

  // Decide which pointer moves happen this cycle.
  // A pop is only legal with data present. A push is legal when there is
  // room, or when a simultaneous pop frees a slot.
  always_comb begin
    w_pop  = rd & ~r_empty;
    w_push = wr & (~r_full | w_pop);
    w_drop = wr & ~w_push;
    w_op   = fifo_op_e'({w_push, w_pop});
  end

  // Work out the next fill level from the net operation.
  always_comb begin
    w_level_next = r_level;
    case (w_op)
      OP_IDLE: w_level_next = r_level;
      OP_PUSH: w_level_next = r_level + LVL_ONE;
      OP_POP:  w_level_next = r_level - LVL_ONE;
      OP_BOTH: w_level_next = r_level;
      default: w_level_next = r_level;
    endcase
  end

  // Advance the pointers. Both wrap naturally at 2**ADDR_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= {ADDR_W{1'b0}};
      r_rd_ptr <= {ADDR_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1'b1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1'b1);
      end
    end
  end

  // Register the level together with the empty and full flags derived
  // from it, so all three always agree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level <= LVL_ZERO;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_level <= w_level_next;
      r_empty <= (w_level_next == LVL_ZERO);
      r_full  <= (w_level_next == LVL_FULL);
    end
  end

  // Sticky overrun flag. A drop in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_OVR_CNT_EN
  logic [OVR_CNT_W-1:0] r_ovr_count;

  // Count dropped characters, saturating at all-ones. A clear that
  // coincides with a drop restarts the count at one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovr_count <= {OVR_CNT_W{1'b0}};
    end else if (w_drop) begin
      if (clr_overrun) begin
        r_ovr_count <= OVR_CNT_W'(1'b1);
      end else if (r_ovr_count != {OVR_CNT_W{1'b1}}) begin
        r_ovr_count <= r_ovr_count + OVR_CNT_W'(1'b1);
      end
    end else if (clr_overrun) begin
      r_ovr_count <= {OVR_CNT_W{1'b0}};
    end
  end

  assign ovr_count = r_ovr_count;
`endif

  uart_fifo_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (r_data)
  );

  assign empty   = r_empty;
  assign full    = r_full;
  assign level   = r_level;
  assign overrun = r_overrun;

endmodule
